// File: rtl/fetch_debug_pkg.sv
// Shared definitions for the debug-unit fetch controller: FSM encoding,
// UART command bytes and the end-of-program marker.
// No logic; constants and types only.
package fetch_debug_pkg;

  typedef enum logic [2:0] {
    ST_LOAD      = 3'd0,
    ST_WAIT_MODE = 3'd1,
    ST_RUN       = 3'd2,
    ST_STEP_WAIT = 3'd3,
    ST_STEP_EXEC = 3'd4,
    ST_DONE      = 3'd5
  } state_t;

  localparam logic [7:0]  CMD_CONT = 8'h43;  // 'C'
  localparam logic [7:0]  CMD_STEP = 8'h53;  // 'S'
  localparam logic [7:0]  CMD_NEXT = 8'h4E;  // 'N'

  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/fetch_debug_controller_byte_word_assembler.sv
// Packs four UART bytes big-endian into one 32-bit word.
// Latency: word/word_valid are combinational in the cycle of the 4th byte strobe.
// Backpressure: none; every rx_done strobe is consumed while enable is high.
module byte_word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  input  logic        enable,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  byte_idx;
  logic [23:0] partial;

  // Shift accepted bytes in from the bottom; the 2-bit index wraps 3->0 by itself
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_idx <= 2'd0;
      partial  <= 24'd0;
    end else if (enable && rx_done) begin
      byte_idx <= byte_idx + 2'd1;
      partial  <= {partial[15:0], rx_data};
    end
  end

  // The completing byte is appended directly so the owner can register the word on this edge
  assign word       = {partial, rx_data};
  assign word_valid = enable && rx_done && (byte_idx == 2'd3);

endmodule

// File: rtl/fetch_debug_controller.sv
// Loads a program over UART into instruction memory, then gates fetch (continuous or single-step) until HALT.
// Latency: write strobe/data registered on the edge that captures the 4th byte; stop_debug registered.
// Backpressure: none; UART bytes are accepted or ignored by state, never stalled.
module fetch_debug_controller
  import fetch_debug_pkg::*;
#(
  parameter int          MAX_INSTR = 256,
  parameter int          CNT_W     = 9,
  parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_done,
  input  logic [31:0]      inInstruction,
  output logic             wr_instruction,
  output logic [31:0]      data_instruction,
  output logic             stop_debug,
  output logic [CNT_W-1:0] outLoadCount,
  output logic [2:0]       outState,
  output logic             outError
);

  state_t           state;
  logic [31:0]      asm_word;
  logic             asm_word_valid;
  logic             halt_seen;
  logic [CNT_W-1:0] next_count;

  byte_word_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .enable    (state == ST_LOAD),
    .word      (asm_word),
    .word_valid(asm_word_valid)
  );

  assign halt_seen  = (inInstruction == HALT_WORD);
  assign next_count = outLoadCount + 1'b1;
  assign outState   = state;

  // Control FSM: program load, mode select, run/step gating of fetch, HALT freeze
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= ST_LOAD;
      wr_instruction   <= 1'b0;
      data_instruction <= 32'd0;
      stop_debug       <= 1'b1;
      outLoadCount     <= '0;
      outError         <= 1'b0;
    end else begin
      wr_instruction <= 1'b0;
      case (state)
        ST_LOAD: begin
          if (asm_word_valid) begin
            wr_instruction   <= 1'b1;
            data_instruction <= asm_word;
            outLoadCount     <= next_count;
            // HALT word is still written so the pipeline can detect it later
            if (asm_word == HALT_WORD) begin
              state <= ST_WAIT_MODE;
            end else if (next_count == CNT_W'(MAX_INSTR)) begin
              outError <= 1'b1;
              state    <= ST_WAIT_MODE;
            end
          end
        end
        ST_WAIT_MODE: begin
          if (rx_done && rx_data == CMD_CONT) begin
            state      <= ST_RUN;
            stop_debug <= 1'b0;
          end else if (rx_done && rx_data == CMD_STEP) begin
            state <= ST_STEP_WAIT;
          end
        end
        ST_RUN: begin
          if (halt_seen) begin
            state      <= ST_DONE;
            stop_debug <= 1'b1;
          end
        end
        ST_STEP_WAIT: begin
          // HALT wins over a simultaneous step request
          if (halt_seen) begin
            state <= ST_DONE;
          end else if (rx_done && rx_data == CMD_NEXT) begin
            state      <= ST_STEP_EXEC;
            stop_debug <= 1'b0;
          end
        end
        ST_STEP_EXEC: begin
          // Release lasts exactly one clock
          stop_debug <= 1'b1;
          state      <= halt_seen ? ST_DONE : ST_STEP_WAIT;
        end
        ST_DONE: begin
          stop_debug <= 1'b1;
        end
        default: begin
          state      <= ST_DONE;
          stop_debug <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_debug_controller.sv
module tb_fetch_debug_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_done = 1'b0;
  logic [31:0] inInstruction = 32'd0;

  logic        wr1, stop1, err1;
  logic [31:0] data1;
  logic [8:0]  cnt1;
  logic [2:0]  st1;

  logic        wr2, stop2, err2;
  logic [31:0] data2;
  logic [2:0]  cnt2;
  logic [2:0]  st2;

  int tests = 0;
  int fails = 0;

  int          wr_cnt1, wr_cnt2, stop0_cnt, win_cnt;
  logic        stop_prev;
  logic [31:0] wr_q[$];

  always #5 clk = ~clk;

  fetch_debug_controller dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
    .inInstruction(inInstruction), .wr_instruction(wr1),
    .data_instruction(data1), .stop_debug(stop1),
    .outLoadCount(cnt1), .outState(st1), .outError(err1)
  );

  fetch_debug_controller #(.MAX_INSTR(4), .CNT_W(3)) dut_small (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
    .inInstruction(inInstruction), .wr_instruction(wr2),
    .data_instruction(data2), .stop_debug(stop2),
    .outLoadCount(cnt2), .outState(st2), .outError(err2)
  );

  // Observe outputs mid-cycle, away from the active edge
  always @(negedge clk) begin
    if (wr1 === 1'b1) begin
      wr_cnt1++;
      wr_q.push_back(data1);
    end
    if (wr2 === 1'b1) wr_cnt2++;
    if (stop1 === 1'b0) stop0_cnt++;
    if (stop1 === 1'b0 && stop_prev === 1'b1) win_cnt++;
    stop_prev = stop1;
  end

  task automatic clear_mon();
    wr_cnt1 = 0; wr_cnt2 = 0; stop0_cnt = 0; win_cnt = 0; stop_prev = 1'b1;
    wr_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; rx_done = 1'b0; inInstruction = 32'd0;
    @(negedge clk);
    rst = 1'b0;
    #1 clear_mon();
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b; rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  // Four bytes on consecutive cycles; rx_done left high for the caller to chain or idle
  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rx_data = w[31-8*i -: 8];
      rx_done = 1'b1;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic load_program();
    send_word(32'h0000_002A);
    send_word(32'h2001_0005);
    send_word(32'hFFFF_FFFF);
    idle();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    if (st1 !== 3'd0) begin $display("FAIL reset_state: got %0d expected 0", st1); fails++; end
    tests++;
    if (wr1 !== 1'b0) begin $display("FAIL reset_wr: got %b expected 0", wr1); fails++; end
    tests++;
    if (data1 !== 32'd0) begin $display("FAIL reset_data: got %h expected 0", data1); fails++; end
    tests++;
    if (stop1 !== 1'b1) begin $display("FAIL reset_stop: got %b expected 1", stop1); fails++; end
    tests++;
    if (cnt1 !== 9'd0) begin $display("FAIL reset_count: got %0d expected 0", cnt1); fails++; end
    tests++;
    if (err1 !== 1'b0) begin $display("FAIL reset_err: got %b expected 0", err1); fails++; end
    tests++;
  endtask

  // Words sent back to back: the 5th byte coincides with the first write pulse
  task automatic test_load();
    logic [31:0] exp_w [3];
    exp_w[0] = 32'h0000_002A; exp_w[1] = 32'h2001_0005; exp_w[2] = 32'hFFFF_FFFF;
    do_reset();
    load_program();
    if (wr_cnt1 !== 3) begin $display("FAIL load_pulses: got %0d expected 3", wr_cnt1); fails++; end
    tests++;
    for (int i = 0; i < 3; i++) begin
      if (wr_q.size() > i && wr_q[i] !== exp_w[i]) begin
        $display("FAIL load_data%0d: got %h expected %h", i, wr_q[i], exp_w[i]); fails++;
      end
      tests++;
    end
    if (cnt1 !== 9'd3) begin $display("FAIL load_count: got %0d expected 3", cnt1); fails++; end
    tests++;
    if (st1 !== 3'd1) begin $display("FAIL load_state: got %0d expected 1", st1); fails++; end
    tests++;
    if (stop0_cnt !== 0) begin $display("FAIL load_stop: got %0d released cycles expected 0", stop0_cnt); fails++; end
    tests++;
  endtask

  task automatic test_run();
    do_reset();
    load_program();
    send_byte(8'h43);
    inInstruction = 32'h0000_002A;
    #1;
    stop0_cnt = 0;
    if (st1 !== 3'd2) begin $display("FAIL run_state: got %0d expected 2", st1); fails++; end
    tests++;
    repeat (5) @(negedge clk);
    #1;
    if (stop0_cnt !== 5) begin $display("FAIL run_released: got %0d expected 5", stop0_cnt); fails++; end
    tests++;
    inInstruction = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    if (stop1 !== 1'b1) begin $display("FAIL run_halt_stop: got %b expected 1", stop1); fails++; end
    tests++;
    if (st1 !== 3'd5) begin $display("FAIL run_halt_state: got %0d expected 5", st1); fails++; end
    tests++;
  endtask

  task automatic test_step();
    do_reset();
    load_program();
    send_byte(8'h53);
    #1;
    if (st1 !== 3'd3) begin $display("FAIL step_enter: got %0d expected 3", st1); fails++; end
    tests++;
    stop0_cnt = 0; win_cnt = 0; stop_prev = 1'b1;
    for (int k = 0; k < 3; k++) begin
      send_byte(8'h4E);
      repeat (9) @(negedge clk);
      #1;
      if (st1 !== 3'd3) begin $display("FAIL step_after%0d: got %0d expected 3", k, st1); fails++; end
      tests++;
    end
    if (stop0_cnt !== 3) begin $display("FAIL step_cycles: got %0d expected 3", stop0_cnt); fails++; end
    tests++;
    if (win_cnt !== 3) begin $display("FAIL step_windows: got %0d expected 3", win_cnt); fails++; end
    tests++;
  endtask

  task automatic test_overflow();
    do_reset();
    send_word(32'h0102_0304);
    send_word(32'h0506_0708);
    send_word(32'h090A_0B0C);
    send_word(32'h0D0E_0F10);
    idle();
    repeat (2) @(negedge clk);
    if (wr_cnt2 !== 4) begin $display("FAIL ovf_pulses: got %0d expected 4", wr_cnt2); fails++; end
    tests++;
    if (err2 !== 1'b1) begin $display("FAIL ovf_error: got %b expected 1", err2); fails++; end
    tests++;
    if (st2 !== 3'd1) begin $display("FAIL ovf_state: got %0d expected 1", st2); fails++; end
    tests++;
    if (data2 !== 32'h0D0E_0F10) begin $display("FAIL ovf_last_data: got %h expected 0d0e0f10", data2); fails++; end
    tests++;
    send_word(32'h1111_1111);
    idle();
    repeat (2) @(negedge clk);
    if (wr_cnt2 !== 4) begin $display("FAIL ovf_extra_word: got %0d pulses expected 4", wr_cnt2); fails++; end
    tests++;
    if (cnt2 !== 3'd4) begin $display("FAIL ovf_count: got %0d expected 4", cnt2); fails++; end
    tests++;
    if (err1 !== 1'b0) begin $display("FAIL ovf_big_noerr: got %b expected 0", err1); fails++; end
    tests++;
  endtask

  task automatic test_reset_midload();
    do_reset();
    send_word(32'hA1A2_A3A4);
    @(negedge clk); rx_data = 8'hB1;
    @(negedge clk); rx_data = 8'hB2;
    @(negedge clk);
    rx_done = 1'b0;
    rst = 1'b1;
    #1;
    if ({st1, wr1, stop1, err1} !== 6'b000_0_1_0) begin
      $display("FAIL midrst_ctrl: got st=%0d wr=%b stop=%b err=%b expected 0 0 1 0", st1, wr1, stop1, err1); fails++;
    end
    tests++;
    if (data1 !== 32'd0 || cnt1 !== 9'd0) begin
      $display("FAIL midrst_data: got data=%h cnt=%0d expected 0 0", data1, cnt1); fails++;
    end
    tests++;
    @(negedge clk);
    rst = 1'b0;
    #1 clear_mon();
    send_word(32'h1234_5678);
    idle();
    repeat (2) @(negedge clk);
    if (cnt1 !== 9'd1) begin $display("FAIL midrst_count: got %0d expected 1", cnt1); fails++; end
    tests++;
    if (data1 !== 32'h1234_5678) begin $display("FAIL midrst_word: got %h expected 12345678", data1); fails++; end
    tests++;
    if (wr_cnt1 !== 1) begin $display("FAIL midrst_pulses: got %0d expected 1", wr_cnt1); fails++; end
    tests++;
  endtask

  task automatic test_cmd_ignore();
    do_reset();
    load_program();
    send_byte(8'h41);
    #1;
    if (st1 !== 3'd1) begin $display("FAIL ign_other: got %0d expected 1", st1); fails++; end
    tests++;
    send_byte(8'h53);
    #1;
    if (st1 !== 3'd3) begin $display("FAIL ign_step: got %0d expected 3", st1); fails++; end
    tests++;
    // HALT and 'N' in the same cycle: HALT wins, no release
    @(negedge clk);
    stop0_cnt = 0;
    rx_data = 8'h4E; rx_done = 1'b1; inInstruction = 32'hFFFF_FFFF;
    @(negedge clk);
    rx_done = 1'b0;
    #1;
    if (st1 !== 3'd5) begin $display("FAIL halt_prio_state: got %0d expected 5", st1); fails++; end
    tests++;
    if (stop0_cnt !== 0) begin $display("FAIL halt_prio_stop: got %0d released cycles expected 0", stop0_cnt); fails++; end
    tests++;
    inInstruction = 32'd0;
    send_byte(8'h4E);
    repeat (2) @(negedge clk);
    #1;
    if (st1 !== 3'd5 || stop1 !== 1'b1) begin
      $display("FAIL done_sticky: got st=%0d stop=%b expected 5 1", st1, stop1); fails++;
    end
    tests++;
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_load();
    test_run();
    test_step();
    test_overflow();
    test_reset_midload();
    test_cmd_ignore();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
